// File: rtl/pipe_ctrl_if.sv
// Pipeline-side control bundle for pipe_ctrl: hazard/halt/branch info in,
// advance/stall/flush out. The pipeline owns master, the controller slave.
interface pipe_ctrl_if;
  logic       halt_req;
  logic       branch_taken;
  logic [2:0] dec_src0;
  logic [2:0] dec_src1;
  logic [1:0] dec_src_used;
  logic [2:0] ex_dest;
  logic       ex_wr;
  logic       ex_valid;
  logic       stage_en;
  logic       stall;
  logic       flush;

  modport master (
    output halt_req, branch_taken,
    output dec_src0, dec_src1, dec_src_used,
    output ex_dest, ex_wr, ex_valid,
    input  stage_en, stall, flush
  );

  modport slave (
    input  halt_req, branch_taken,
    input  dec_src0, dec_src1, dec_src_used,
    input  ex_dest, ex_wr, ex_valid,
    output stage_en, stall, flush
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Run/step/halt sequencer, RAW stall and branch flush for the 3-stage pipe.
// Optional step-key debounce filter enabled by defining STEP_DEBOUNCE_EN.
module pipe_ctrl #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter int          CNT_W           = 16
) (
  input  logic             clk,
  input  logic             CPU_RESET_n,
  input  logic             run_sw,
  input  logic             step_n,
  pipe_ctrl_if.slave       bus,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    HALTED = 2'd3
  } st_t;

  st_t        st;
  logic       en_q;
  logic [1:0] flush_cnt;
  logic       sync1, sync2;
  logic       lvl, lvl_q;
  logic       step_pulse;
  logic       hit0, hit1, haz;
  logic       flush, stall, halt_ok;

  always_ff @(posedge clk or negedge CPU_RESET_n) begin
    if (!CPU_RESET_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= step_n;
      sync2 <= sync1;
    end
  end

`ifdef STEP_DEBOUNCE_EN
  logic [15:0] db_cnt;
  logic        filt;

  always_ff @(posedge clk or negedge CPU_RESET_n) begin
    if (!CPU_RESET_n) begin
      db_cnt <= 16'd0;
      filt   <= 1'b1;
    end else if (sync2 == filt) begin
      db_cnt <= 16'd0;
    end else if (db_cnt == DEBOUNCE_CYCLES - 16'd1) begin
      filt   <= sync2;
      db_cnt <= 16'd0;
    end else begin
      db_cnt <= db_cnt + 16'd1;
    end
  end

  assign lvl = filt;
`else
  logic unused_db;
  assign unused_db = ^DEBOUNCE_CYCLES;
  assign lvl = sync2;
`endif

  // Registered edge detect: third flop after the pin gives the pulse.
  always_ff @(posedge clk or negedge CPU_RESET_n) begin
    if (!CPU_RESET_n) begin
      lvl_q      <= 1'b1;
      step_pulse <= 1'b0;
    end else begin
      lvl_q      <= lvl;
      step_pulse <= lvl_q & ~lvl;
    end
  end

  assign hit0 = bus.dec_src_used[0] &
                (bus.dec_src0 == bus.ex_dest);
  assign hit1 = bus.dec_src_used[1] &
                (bus.dec_src1 == bus.ex_dest);
  assign haz  = bus.ex_wr & bus.ex_valid &
                (bus.ex_dest != 3'd7) &
                (hit0 | hit1);

  assign flush   = (flush_cnt != 2'd0);
  assign stall   = haz & en_q & ~flush;
  assign halt_ok = bus.halt_req & ~flush & ~stall;

  always_ff @(posedge clk or negedge CPU_RESET_n) begin
    if (!CPU_RESET_n) begin
      st   <= IDLE;
      en_q <= 1'b0;
    end else begin
      unique case (st)
        IDLE: begin
          if (run_sw) begin
            st   <= RUN;
            en_q <= 1'b1;
          end else if (step_pulse) begin
            st   <= STEP;
            en_q <= 1'b1;
          end
        end
        STEP: begin
          en_q <= 1'b0;
          st   <= halt_ok ? HALTED : IDLE;
        end
        RUN: begin
          if (!run_sw) begin
            st   <= IDLE;
            en_q <= 1'b0;
          end else if (halt_ok) begin
            st   <= HALTED;
            en_q <= 1'b0;
          end
        end
        HALTED: begin
          if (!run_sw) st <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge CPU_RESET_n) begin
    if (!CPU_RESET_n) begin
      flush_cnt <= 2'd0;
      retired   <= '0;
    end else if (en_q) begin
      if (bus.branch_taken)
        flush_cnt <= 2'd2;
      else if (flush)
        flush_cnt <= flush_cnt - 2'd1;
      if (bus.ex_valid)
        retired <= retired + CNT_W'(1);
    end
  end

  assign bus.stage_en = en_q;
  assign bus.stall    = stall;
  assign bus.flush    = flush;
  assign state        = st;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: step, run, hazard, flush, halt, wrap, reset.
// Step latency tracks the STEP_DEBOUNCE_EN build.
module tb_pipe_ctrl;

  localparam int CW = 4;
`ifdef STEP_DEBOUNCE_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 3;
`endif

  logic          clk = 1'b0;
  logic          CPU_RESET_n;
  logic          run_sw;
  logic          step_n;
  logic [1:0]    state;
  logic [CW-1:0] retired;
  int            pass_cnt = 0;
  int            total = 0;

  pipe_ctrl_if pif();

  pipe_ctrl #(
    .DEBOUNCE_CYCLES(16'd4),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .CPU_RESET_n(CPU_RESET_n),
    .run_sw(run_sw),
    .step_n(step_n),
    .bus(pif),
    .state(state),
    .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_haz();
    pif.ex_wr        = 1'b0;
    pif.ex_dest      = 3'd0;
    pif.dec_src0     = 3'd1;
    pif.dec_src1     = 3'd2;
    pif.dec_src_used = 2'b00;
  endtask

  task automatic set_haz();
    pif.ex_wr        = 1'b1;
    pif.ex_valid     = 1'b1;
    pif.ex_dest      = 3'd3;
    pif.dec_src0     = 3'd3;
    pif.dec_src_used = 2'b01;
  endtask

  task automatic test_reset();
    CPU_RESET_n = 1'b0;
    run_sw = 1'b0;
    step_n = 1'b1;
    pif.halt_req = 1'b0;
    pif.branch_taken = 1'b0;
    pif.dec_src1 = 3'd2;
    set_haz();
    #2;
    total++;
    if (state !== 2'd0)
      $display("FAIL rst_state: got %0d exp 0", state);
    else pass_cnt++;
    total++;
    if (pif.stage_en !== 1'b0)
      $display("FAIL rst_en: got %b exp 0", pif.stage_en);
    else pass_cnt++;
    total++;
    if (pif.stall !== 1'b0 || pif.flush !== 1'b0)
      $display("FAIL rst_sf: got %b%b exp 00",
               pif.stall, pif.flush);
    else pass_cnt++;
    total++;
    if (retired !== '0)
      $display("FAIL rst_ret: got %0d exp 0", retired);
    else pass_cnt++;
    tick();
    tick();
    clr_haz();
    pif.ex_valid = 1'b0;
    CPU_RESET_n = 1'b1;
    tick();
  endtask

  task automatic test_step();
    pif.ex_valid = 1'b1;
    step_n = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      tick();
      total++;
      if (pif.stage_en !== 1'b0 || state !== 2'd0)
        $display("FAIL step_wait%0d: got en=%b st=%0d exp 0/0",
                 i, pif.stage_en, state);
      else pass_cnt++;
    end
    tick();
    total++;
    if (state !== 2'd2 || pif.stage_en !== 1'b1)
      $display("FAIL step_on: got st=%0d en=%b exp 2/1",
               state, pif.stage_en);
    else pass_cnt++;
    tick();
    total++;
    if (state !== 2'd0 || pif.stage_en !== 1'b0)
      $display("FAIL step_off: got st=%0d en=%b exp 0/0",
               state, pif.stage_en);
    else pass_cnt++;
    total++;
    if (retired !== CW'(1))
      $display("FAIL step_ret: got %0d exp 1", retired);
    else pass_cnt++;
    repeat (4) tick();
    total++;
    if (pif.stage_en !== 1'b0 || retired !== CW'(1))
      $display("FAIL step_once: got en=%b ret=%0d exp 0/1",
               pif.stage_en, retired);
    else pass_cnt++;
    step_n = 1'b1;
    repeat (LAT + 3) tick();
  endtask

  task automatic test_run();
    pif.ex_valid = 1'b1;
    run_sw = 1'b1;
    tick();
    total++;
    if (state !== 2'd1 || retired !== CW'(1))
      $display("FAIL run_enter: got st=%0d ret=%0d exp 1/1",
               state, retired);
    else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (pif.stage_en !== 1'b1)
        $display("FAIL run_en%0d: got %b exp 1",
                 i, pif.stage_en);
      else pass_cnt++;
    end
    total++;
    if (retired !== CW'(11))
      $display("FAIL run_ret: got %0d exp 11", retired);
    else pass_cnt++;
    run_sw = 1'b0;
    tick();
    total++;
    if (state !== 2'd0 || retired !== CW'(12))
      $display("FAIL run_exit: got st=%0d ret=%0d exp 0/12",
               state, retired);
    else pass_cnt++;
    repeat (3) tick();
    total++;
    if (retired !== CW'(12) || pif.stage_en !== 1'b0)
      $display("FAIL run_frozen: got ret=%0d en=%b exp 12/0",
               retired, pif.stage_en);
    else pass_cnt++;
  endtask

  task automatic test_hazard();
    set_haz();
    #1;
    total++;
    if (pif.stall !== 1'b0)
      $display("FAIL haz_idle: got %b exp 0", pif.stall);
    else pass_cnt++;
    run_sw = 1'b1;
    tick();
    total++;
    if (pif.stall !== 1'b1)
      $display("FAIL haz_src0: got %b exp 1", pif.stall);
    else pass_cnt++;
    pif.ex_dest = 3'd7;
    pif.dec_src0 = 3'd7;
    #1;
    total++;
    if (pif.stall !== 1'b0)
      $display("FAIL haz_r7: got %b exp 0", pif.stall);
    else pass_cnt++;
    pif.ex_dest = 3'd5;
    pif.dec_src0 = 3'd3;
    pif.dec_src1 = 3'd5;
    pif.dec_src_used = 2'b10;
    #1;
    total++;
    if (pif.stall !== 1'b1)
      $display("FAIL haz_src1: got %b exp 1", pif.stall);
    else pass_cnt++;
    pif.dec_src_used = 2'b00;
    #1;
    total++;
    if (pif.stall !== 1'b0)
      $display("FAIL haz_unused: got %b exp 0", pif.stall);
    else pass_cnt++;
    pif.dec_src_used = 2'b11;
    pif.ex_wr = 1'b0;
    #1;
    total++;
    if (pif.stall !== 1'b0)
      $display("FAIL haz_nowr: got %b exp 0", pif.stall);
    else pass_cnt++;
    pif.ex_wr = 1'b1;
    pif.ex_valid = 1'b0;
    #1;
    total++;
    if (pif.stall !== 1'b0)
      $display("FAIL haz_noval: got %b exp 0", pif.stall);
    else pass_cnt++;
    clr_haz();
    pif.ex_valid = 1'b1;
    tick();
  endtask

  task automatic test_flush();
    pif.branch_taken = 1'b1;
    #1;
    total++;
    if (pif.flush !== 1'b0)
      $display("FAIL fl_pre: got %b exp 0", pif.flush);
    else pass_cnt++;
    tick();
    pif.branch_taken = 1'b0;
    set_haz();
    #1;
    total++;
    if (pif.flush !== 1'b1 || pif.stall !== 1'b0)
      $display("FAIL fl_1: got f=%b s=%b exp 1/0",
               pif.flush, pif.stall);
    else pass_cnt++;
    tick();
    total++;
    if (pif.flush !== 1'b1 || pif.stall !== 1'b0)
      $display("FAIL fl_2: got f=%b s=%b exp 1/0",
               pif.flush, pif.stall);
    else pass_cnt++;
    tick();
    total++;
    if (pif.flush !== 1'b0 || pif.stall !== 1'b1)
      $display("FAIL fl_end: got f=%b s=%b exp 0/1",
               pif.flush, pif.stall);
    else pass_cnt++;
    clr_haz();
    pif.branch_taken = 1'b1;
    tick();
    pif.branch_taken = 1'b0;
    tick();
    pif.branch_taken = 1'b1;
    tick();
    pif.branch_taken = 1'b0;
    tick();
    total++;
    if (pif.flush !== 1'b1)
      $display("FAIL fl_reload: got %b exp 1", pif.flush);
    else pass_cnt++;
    tick();
    total++;
    if (pif.flush !== 1'b0)
      $display("FAIL fl_reload_end: got %b exp 0", pif.flush);
    else pass_cnt++;
  endtask

  task automatic test_halt();
    set_haz();
    pif.halt_req = 1'b1;
    tick();
    total++;
    if (state !== 2'd1)
      $display("FAIL halt_stall: got %0d exp 1", state);
    else pass_cnt++;
    clr_haz();
    pif.halt_req = 1'b0;
    pif.branch_taken = 1'b1;
    tick();
    pif.branch_taken = 1'b0;
    pif.halt_req = 1'b1;
    tick();
    total++;
    if (state !== 2'd1)
      $display("FAIL halt_fl1: got %0d exp 1", state);
    else pass_cnt++;
    tick();
    total++;
    if (state !== 2'd1)
      $display("FAIL halt_fl2: got %0d exp 1", state);
    else pass_cnt++;
    tick();
    total++;
    if (state !== 2'd3 || pif.stage_en !== 1'b0)
      $display("FAIL halt_on: got st=%0d en=%b exp 3/0",
               state, pif.stage_en);
    else pass_cnt++;
    pif.halt_req = 1'b0;
    step_n = 1'b0;
    for (int i = 0; i < LAT + 4; i++) begin
      tick();
      total++;
      if (state !== 2'd3 || pif.stage_en !== 1'b0)
        $display("FAIL halt_step%0d: got st=%0d en=%b exp 3/0",
                 i, state, pif.stage_en);
      else pass_cnt++;
    end
    step_n = 1'b1;
    repeat (LAT + 4) tick();
    run_sw = 1'b0;
    tick();
    total++;
    if (state !== 2'd0)
      $display("FAIL halt_exit: got %0d exp 0", state);
    else pass_cnt++;
  endtask

  task automatic test_step_vs_run();
    pif.ex_valid = 1'b0;
    step_n = 1'b0;
    repeat (LAT) tick();
    run_sw = 1'b1;
    tick();
    total++;
    if (state !== 2'd1)
      $display("FAIL svr_run: got %0d exp 1", state);
    else pass_cnt++;
    run_sw = 1'b0;
    tick();
    repeat (4) tick();
    total++;
    if (state !== 2'd0 || pif.stage_en !== 1'b0)
      $display("FAIL svr_drop: got st=%0d en=%b exp 0/0",
               state, pif.stage_en);
    else pass_cnt++;
    step_n = 1'b1;
    repeat (LAT + 4) tick();
  endtask

  task automatic test_wrap();
    CPU_RESET_n = 1'b0;
    #1;
    CPU_RESET_n = 1'b1;
    pif.ex_valid = 1'b1;
    run_sw = 1'b1;
    tick();
    repeat (15) tick();
    total++;
    if (retired !== CW'(15))
      $display("FAIL wrap_max: got %0d exp 15", retired);
    else pass_cnt++;
    tick();
    total++;
    if (retired !== CW'(0))
      $display("FAIL wrap_zero: got %0d exp 0", retired);
    else pass_cnt++;
    tick();
    total++;
    if (retired !== CW'(1))
      $display("FAIL wrap_one: got %0d exp 1", retired);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    pif.branch_taken = 1'b1;
    tick();
    pif.branch_taken = 1'b0;
    #1;
    CPU_RESET_n = 1'b0;
    #1;
    total++;
    if (state !== 2'd0 || pif.stage_en !== 1'b0 ||
        pif.flush !== 1'b0 || retired !== '0)
      $display("FAIL rst_mid: got st=%0d en=%b f=%b ret=%0d exp 0/0/0/0",
               state, pif.stage_en, pif.flush, retired);
    else pass_cnt++;
    run_sw = 1'b0;
    pif.ex_valid = 1'b0;
    tick();
    CPU_RESET_n = 1'b1;
    tick();
    total++;
    if (pif.flush !== 1'b0 || state !== 2'd0)
      $display("FAIL rst_mid_after: got f=%b st=%0d exp 0/0",
               pif.flush, state);
    else pass_cnt++;
  endtask

`ifdef STEP_DEBOUNCE_EN
  task automatic test_debounce();
    int n;
    n = 0;
    step_n = 1'b0;
    repeat (3) tick();
    step_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (pif.stage_en) n++;
    end
    total++;
    if (n !== 0)
      $display("FAIL db_bounce: got %0d steps exp 0", n);
    else pass_cnt++;
    n = 0;
    step_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (pif.stage_en) n++;
    end
    step_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (pif.stage_en) n++;
    end
    total++;
    if (n !== 1)
      $display("FAIL db_step: got %0d steps exp 1", n);
    else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_step();
    test_run();
    test_hazard();
    test_flush();
    test_halt();
    test_step_vs_run();
    test_wrap();
    test_reset_mid();
`ifdef STEP_DEBOUNCE_EN
    test_debounce();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
